// File: rtl/ccg_bist_sig_engine.sv
// Self-test wrapper for combinational benchmark circuits: a Galois LFSR drives
// the circuit, a Galois MISR compacts its (optionally pipelined) responses.
module ccg_bist_sig_engine #(
    parameter int               N_IN      = 24,
    parameter int               N_OUT     = 17,
    parameter int               CNT_W     = 16,
    parameter int               LAT       = 0,
    parameter logic [N_IN-1:0]  LFSR_TAPS = 24'hE10000,
    parameter logic [N_OUT-1:0] MISR_TAPS = 17'h12000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [N_IN-1:0]  seed,
    output logic [N_IN-1:0]  pat_o,
    output logic             pat_valid,
    input  logic [N_OUT-1:0] resp_i,
    output logic             busy,
    output logic             done,
    output logic [N_OUT-1:0] signature,
    output logic [CNT_W-1:0] vec_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_SEED, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [3:0] LAT_C = 4'(LAT);

    state_t           state;
    logic [CNT_W-1:0] nv_q;
    logic [3:0]       drain_cnt;
    logic [N_IN-1:0]  lfsr_next;
    logic [N_OUT-1:0] misr_next;
    logic [LAT:0]     vld_pipe;
    logic             resp_vld;
    logic             last_vec;

    assign lfsr_next = (pat_o >> 1) ^ (pat_o[0] ? LFSR_TAPS : '0);
    assign misr_next = (signature >> 1) ^ (signature[0] ? MISR_TAPS : '0) ^ resp_i;
    assign last_vec  = (vec_cnt == nv_q);
    assign resp_vld  = vld_pipe[LAT];

    // vld_pipe[k] marks that the response arriving now belongs to a vector issued k cycles ago
    generate
        if (LAT == 0) begin : g_nodly
            assign vld_pipe = pat_valid;
        end else begin : g_dly
            logic [LAT-1:0] dly;
            assign vld_pipe = {dly, pat_valid};
            always_ff @(posedge clk) begin
                if (!rst_n) dly <= '0;
                else        dly <= vld_pipe[LAT-1:0];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pat_o     <= '0;
            pat_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            signature <= '0;
            vec_cnt   <= '0;
            nv_q      <= '0;
            drain_cnt <= '0;
        end else begin
            if (resp_vld) signature <= misr_next;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        nv_q      <= num_vec;
                        signature <= '0;
                        vec_cnt   <= '0;
                        if (num_vec == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= S_SEED;
                            // an all-zero seed would lock the LFSR at zero
                            pat_o     <= (seed == '0) ? N_IN'(1) : seed;
                            pat_valid <= 1'b1;
                            vec_cnt   <= CNT_W'(1);
                            busy      <= 1'b1;
                            done      <= 1'b0;
                        end
                    end
                end
                S_SEED, S_RUN: begin
                    if (last_vec) begin
                        state     <= S_DRAIN;
                        pat_valid <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        state   <= S_RUN;
                        pat_o   <= lfsr_next;
                        vec_cnt <= vec_cnt + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == LAT_C) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
